// File: rtl/data_mem.sv
// Byte-addressable RV32I data memory: valid/ready load/store port, registered response, post-reset scrub.
// Optional fault logging is enabled by defining DMEM_FAULT_LOG_EN.
module data_mem #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [1:0]        rsp_fault_code,
  output logic              init_done
`ifdef DMEM_FAULT_LOG_EN
  ,
  input  logic              fault_clear,
  output logic [7:0]        fault_count,
  output logic [ADDR_W-1:0] fault_addr
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] BYTE_CAP = (ADDR_W+1)'(DEPTH_WORDS * 4);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;
  localparam logic [1:0] FC_SIZE     = 2'b11;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] scrub_ptr_q, scrub_ptr_d;
  logic             req_ready_q, req_ready_d;
  logic             init_done_q, init_done_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_fault_q, rsp_fault_d;
  logic [1:0]       rsp_fault_code_q, rsp_fault_code_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept_c;
  logic             fault_c;
  logic [1:0]       fault_code_c;
  logic [IDX_W-1:0] idx_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [31:0]      rword_c;
  logic [31:0]      lane_c;
  logic [31:0]      load_c;
  logic             scrub_we_c;
  logic             mem_we_c;

  assign accept_c = (state_q == ST_RUN) && req_valid;
  assign idx_c    = req_addr[IDX_W+1:2];
  assign rword_c  = mem_q[idx_c];
  assign lane_c   = rword_c >> {req_addr[1:0], 3'b000};

  // Request decode: fault priority, byte enables, aligned store data, extended load data.
  always_comb begin
    logic illegal, misalign, oor;
    illegal  = 1'b0;
    misalign = 1'b0;
    oor      = ({1'b0, req_addr} >= BYTE_CAP);
    be_c     = 4'b1111;
    wdata_c  = req_wdata;
    load_c   = '0;
    case (req_size)
      3'b000, 3'b100: misalign = 1'b0;
      3'b001, 3'b101: misalign = req_addr[0];
      3'b010:         misalign = |req_addr[1:0];
      default:        illegal  = 1'b1;
    endcase
    if (illegal)       fault_code_c = FC_SIZE;
    else if (misalign) fault_code_c = FC_MISALIGN;
    else if (oor)      fault_code_c = FC_RANGE;
    else               fault_code_c = FC_NONE;
    fault_c = (fault_code_c != FC_NONE);

    case (req_size[1:0])
      2'b00: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase

    case (req_size)
      3'b000:  load_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'b100:  load_c = {24'd0, lane_c[7:0]};
      3'b001:  load_c = {{16{lane_c[15]}}, lane_c[15:0]};
      3'b101:  load_c = {16'd0, lane_c[15:0]};
      3'b010:  load_c = rword_c;
      default: load_c = '0;
    endcase
  end

  // Next-state: scrub sequencing, request acceptance and response formation.
  always_comb begin
    state_d          = state_q;
    scrub_ptr_d      = scrub_ptr_q;
    req_ready_d      = req_ready_q;
    init_done_d      = init_done_q;
    rsp_valid_d      = 1'b0;
    rsp_rdata_d      = '0;
    rsp_fault_d      = 1'b0;
    rsp_fault_code_d = FC_NONE;
    scrub_we_c       = 1'b0;
    mem_we_c         = 1'b0;
    case (state_q)
      ST_INIT: begin
        scrub_we_c  = 1'b1;
        scrub_ptr_d = scrub_ptr_q + IDX_W'(1);
        if (scrub_ptr_q == LAST_IDX) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          req_ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        req_ready_d = 1'b1;
        if (accept_c) begin
          rsp_valid_d = 1'b1;
          if (fault_c) begin
            rsp_fault_d      = 1'b1;
            rsp_fault_code_d = fault_code_c;
          end else if (req_we) begin
            mem_we_c = 1'b1;
          end else begin
            rsp_rdata_d = load_c;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_INIT;
      scrub_ptr_q      <= '0;
      req_ready_q      <= 1'b0;
      init_done_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_fault_q      <= 1'b0;
      rsp_fault_code_q <= FC_NONE;
    end else begin
      state_q          <= state_d;
      scrub_ptr_q      <= scrub_ptr_d;
      req_ready_q      <= req_ready_d;
      init_done_q      <= init_done_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_fault_q      <= rsp_fault_d;
      rsp_fault_code_q <= rsp_fault_code_d;
    end
  end

  // Word array has no reset; the scrub zeroes it instead.
  always_ff @(posedge clk) begin
    if (scrub_we_c) begin
      mem_q[scrub_ptr_q] <= '0;
    end else if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
      end
    end
  end

  assign req_ready      = req_ready_q;
  assign init_done      = init_done_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_fault      = rsp_fault_q;
  assign rsp_fault_code = rsp_fault_code_q;

`ifdef DMEM_FAULT_LOG_EN
  logic [7:0]        fault_count_q, fault_count_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

  // Saturating fault counter; a clear overrides a coincident fault.
  always_comb begin
    fault_count_d = fault_count_q;
    fault_addr_d  = fault_addr_q;
    if (fault_clear) begin
      fault_count_d = '0;
      fault_addr_d  = '0;
    end else if (accept_c && fault_c) begin
      if (fault_count_q != 8'hFF) fault_count_d = fault_count_q + 8'd1;
      fault_addr_d = req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_count_q <= '0;
      fault_addr_q  <= '0;
    end else begin
      fault_count_q <= fault_count_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign fault_count = fault_count_q;
  assign fault_addr  = fault_addr_q;
`endif

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: scrub, loads/stores, faults, reset, optional fault log.
module tb_data_mem;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_fault;
  logic [1:0]    rsp_fault_code;
  logic          init_done;
`ifdef DMEM_FAULT_LOG_EN
  logic          fault_clear;
  logic [7:0]    fault_count;
  logic [AW-1:0] fault_addr;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  data_mem #(.DEPTH_WORDS(DW), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_fault      (rsp_fault),
    .rsp_fault_code (rsp_fault_code),
    .init_done      (init_done)
`ifdef DMEM_FAULT_LOG_EN
    ,
    .fault_clear    (fault_clear),
    .fault_count    (fault_count),
    .fault_addr     (fault_addr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge; consecutive calls are back-to-back.
  task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] rdata, input logic [1:0] code);
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rdata"}, rsp_rdata, rdata);
    check({tag, ".fault"}, {29'd0, rsp_fault, rsp_fault_code}, {29'd0, (code != 2'b00), code});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".outs"},
          {26'd0, req_ready, rsp_valid, rsp_fault, rsp_fault_code, init_done}, 32'd0);
    check({tag, ".rdata"}, rsp_rdata, 32'd0);
  endtask

  // Starts in the first cycle after rst deasserts; ready must stay low for exactly DW cycles.
  task automatic wait_scrub(input string tag);
    int unsigned bad = 0;
    for (int i = 0; i < int'(DW); i++) begin
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || init_done !== 1'b0) bad++;
      tick();
    end
    check({tag, ".init_quiet"}, bad, 32'd0);
    check({tag, ".ready_done"}, {30'd0, req_ready, init_done}, 32'd3);
    check({tag, ".no_rsp"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 3'b010;
    req_addr  = '0;
    req_wdata = '0;
`ifdef DMEM_FAULT_LOG_EN
    fault_clear = 1'b0;
`endif
    repeat (2) tick();
    check_all_zero("reset");

    // Scrub with a load held pending the whole time
    req_valid = 1'b1;
    rst = 1'b0;
    wait_scrub("scrub1");
    tick();
    req_valid = 1'b0;
    check_rsp("lw0_after_scrub", 32'h0000_0000, 2'b00);
    tick();
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);

    // Word store then sub-word loads, one response per accepted request
    issue(1'b1, 3'b010, 32'h80, 32'hDEAD_BEEF);
    check_rsp("sw80", 32'h0, 2'b00);
    issue(1'b0, 3'b000, 32'h80, 32'h0);
    check_rsp("lb80", 32'hFFFF_FFEF, 2'b00);
    issue(1'b0, 3'b100, 32'h83, 32'h0);
    check_rsp("lbu83", 32'h0000_00DE, 2'b00);
    issue(1'b0, 3'b001, 32'h82, 32'h0);
    check_rsp("lh82", 32'hFFFF_DEAD, 2'b00);
    issue(1'b0, 3'b101, 32'h80, 32'h0);
    check_rsp("lhu80", 32'h0000_BEEF, 2'b00);
    issue(1'b0, 3'b000, 32'h82, 32'h0);
    check_rsp("lb82", 32'hFFFF_FFAD, 2'b00);

    // Store immediately followed by a load of the same word
    issue(1'b1, 3'b000, 32'h81, 32'hFFFF_FF12);
    check_rsp("sb81", 32'h0, 2'b00);
    issue(1'b0, 3'b010, 32'h80, 32'h0);
    check_rsp("lw80_after_sb", 32'hDEAD_12EF, 2'b00);
    issue(1'b1, 3'b001, 32'h82, 32'hAAAA_5678);
    check_rsp("sh82", 32'h0, 2'b00);
    issue(1'b0, 3'b010, 32'h80, 32'h0);
    check_rsp("lw80_after_sh", 32'h5678_12EF, 2'b00);
    issue(1'b0, 3'b001, 32'h82, 32'h0);
    check_rsp("lh82_pos", 32'h0000_5678, 2'b00);

    // Faults: priority, no array change, rdata zero, not sticky
    issue(1'b0, 3'b010, 32'h82, 32'h0);
    check_rsp("lw82_misalign", 32'h0, 2'b01);
    issue(1'b0, 3'b001, 32'h81, 32'h0);
    check_rsp("lh81_misalign", 32'h0, 2'b01);
    issue(1'b1, 3'b010, 32'h800, 32'h1234_5678);
    check_rsp("sw800_range", 32'h0, 2'b10);
    issue(1'b0, 3'b010, 32'h0, 32'h0);
    check_rsp("lw0_unchanged", 32'h0, 2'b00);
    issue(1'b1, 3'b011, 32'h803, 32'hFFFF_FFFF);
    check_rsp("f011_size", 32'h0, 2'b11);
    issue(1'b1, 3'b110, 32'h80, 32'hFFFF_FFFF);
    check_rsp("f110_size", 32'h0, 2'b11);
    issue(1'b1, 3'b000, 32'h8000_0081, 32'h0000_0099);
    check_rsp("sb_hi_range", 32'h0, 2'b10);
    issue(1'b0, 3'b010, 32'h80, 32'h0);
    check_rsp("lw80_after_faults", 32'h5678_12EF, 2'b00);
    issue(1'b0, 3'b010, 32'h7FC, 32'h0);
    check_rsp("lw7fc_last", 32'h0, 2'b00);

    // Reset mid-response clears outputs at once, then again mid-scrub
    issue(1'b0, 3'b010, 32'h80, 32'h0);
    check("pre_rst_rdata", rsp_rdata, 32'h5678_12EF);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_rsp");
    #2;
    rst = 1'b0;
    repeat (100) tick();
    check("mid_scrub_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_scrub");
    tick();
    rst = 1'b0;
    wait_scrub("scrub2");
    issue(1'b0, 3'b010, 32'h80, 32'h0);
    check_rsp("lw80_rescrubbed", 32'h0, 2'b00);

`ifdef DMEM_FAULT_LOG_EN
    check("flog_reset_cnt", {24'd0, fault_count}, 32'd0);
    for (int i = 0; i < 300; i++) issue(1'b0, 3'b010, 32'h1000 + 32'(i), 32'h0);
    check("flog_sat_cnt", {24'd0, fault_count}, 32'd255);
    check("flog_last_addr", fault_addr, 32'h0000_112B);
    fault_clear = 1'b1;
    issue(1'b0, 3'b010, 32'h2000, 32'h0);
    fault_clear = 1'b0;
    check("flog_clear_cnt", {24'd0, fault_count}, 32'd0);
    check("flog_clear_addr", fault_addr, 32'd0);
    issue(1'b0, 3'b001, 32'h41, 32'h0);
    check("flog_after_cnt", {24'd0, fault_count}, 32'd1);
    check("flog_after_addr", fault_addr, 32'h0000_0041);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
